// File: rtl/sm_display_scan.sv
// sm_display_scan: time-multiplexed scan controller for a 4-digit seven-segment
// display. It lights one digit at a time for SHOW_CYCLES, then blanks all
// anodes for BLANK_CYCLES so the previous digit does not ghost onto the next.
// Writes land in a pending register and are copied into the displayed shadow
// only at frame boundaries, so a frame never mixes old and new data.
// Optional feature: define SM_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading
// zero digits (digit 0 is always shown).
`timescale 1ns/1ps

module sm_display_scan #(
  parameter int unsigned SHOW_CYCLES  = 256,  // 1..65535
  parameter int unsigned BLANK_CYCLES = 16    // 0 removes the blank phase
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [19:0] wr_data,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } phase_t;

  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 16'd0 : 16'(BLANK_CYCLES - 1);
  localparam bit          HAS_BLANK  = (BLANK_CYCLES != 0);

  logic [19:0] pending_q;
  logic [19:0] shadow_q, shadow_d;
  logic [1:0]  digit_q, digit_d;
  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic        new_frame_q, new_frame_d;
  logic        advance;
  logic [3:0]  nibble;
  logic        lz_blank;
  logic [6:0]  seg_d;
  logic [3:0]  dp_bits;

  // Hex nibble to {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Pending register: captures every CPU-side write, even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else if (wr_en) begin
      // NOTE: sequential state is always assigned with <= so every flop samples
      // the pre-edge values, independent of the order of the blocks.
      pending_q <= wr_data;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      digit_q     <= '0;
      phase_q     <= SHOW;
      cnt_q       <= '0;
      new_frame_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      digit_q     <= digit_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      new_frame_q <= new_frame_d;
    end
  end

  // Next-state logic: dwell counting, digit stepping and frame-boundary reload.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    digit_d     = digit_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q + 16'd1;
    shadow_d    = shadow_q;
    new_frame_d = 1'b0;
    advance     = 1'b0;

    if (!enable) begin
      // Dark and parked at the start of a frame; a write on this same edge wins.
      digit_d  = '0;
      phase_d  = SHOW;
      cnt_d    = '0;
      shadow_d = wr_en ? wr_data : pending_q;
    end else begin
      case (phase_q)
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) phase_d = BLANK;
            else           advance = 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            phase_d = SHOW;
            advance = 1'b1;
          end
        end
      endcase

      if (advance) begin
        digit_d = digit_q + 2'd1;
        if (digit_q == 2'd3) begin
          // Frame boundary: the displayed value changes only here.
          new_frame_d = 1'b1;
          shadow_d    = wr_en ? wr_data : pending_q;
        end
      end
    end
  end

  // Segment pattern for the digit currently selected by the state.
  always_comb begin
    nibble  = shadow_q[{digit_q, 2'b00} +: 4];
    dp_bits = shadow_q[19:16];
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
    case (digit_q)
      2'd0:    lz_blank = 1'b0;
      2'd1:    lz_blank = (shadow_q[15:4]  == 12'h000);
      2'd2:    lz_blank = (shadow_q[15:8]  == 8'h00);
      default: lz_blank = (shadow_q[15:12] == 4'h0);
    endcase
`else
    lz_blank = 1'b0;
`endif
    seg_d = lz_blank ? 7'h00 : hex7(nibble);
  end

  // Registered display outputs; they trail the scan state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else if (!enable || phase_q == BLANK) begin
      anode      <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      anode      <= 4'b0001 << digit_q;
      seg        <= seg_d;
      dp         <= dp_bits[digit_q];
      frame_done <= new_frame_q;
    end
  end

endmodule

// File: tb/tb_sm_display_scan.sv
// tb_sm_display_scan: directed test of sm_display_scan with SHOW_CYCLES=4 and
// BLANK_CYCLES=2 (frame period 24). Outputs are sampled 1 ns after each
// rising edge; edge_n numbers the rising edges since the latest reset release.
`timescale 1ns/1ps

module tb_sm_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_en;
  logic [19:0] wr_data;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  sm_display_scan #(
    .SHOW_CYCLES (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [11:0] disp;
  assign disp = {anode, seg, dp};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Expected segments of digit d for displayed value v.
  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] nib;
    nib = v[d*4 +: 4];
`ifdef SM_DISPLAY_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (d*4)) == 16'h0) return 7'h00;
`endif
    return HEX[nib];
  endfunction

  // Expected {anode, seg, dp} while digit d of value v is lit.
  function automatic logic [11:0] lit(input int d, input logic [19:0] v);
    logic [3:0] a;
    a = 4'b0001 << d;
    return {a, exp_seg(v[15:0], d), v[16+d]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [19:0] shadow_m;
    logic [11:0] exp_d;

    rst_n   = 1'b1;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset disp", disp, 12'h000);
    check("reset frame_done", frame_done, 0);

    // Release with enable high and write 0x01234 on the first edge.
    @(posedge clk); #1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    wr_en   = 1'b1;
    wr_data = 20'h01234;
    edge_n  = -1;
    tick();
    check("first edge digit0", disp, lit(0, 20'h00000));
    check("first edge frame_done", frame_done, 0);
    wr_en = 1'b0;

    // Two full frames: 4 lit / 2 dark per digit, new value from edge 24 on.
    for (int e = 1; e <= 48; e++) begin
      tick();
      shadow_m = (e >= 24) ? 20'h01234 : 20'h00000;
      exp_d    = ((e % 6) < 4) ? lit((e / 6) % 4, shadow_m) : 12'h000;
      check($sformatf("scan e%0d", e), disp, exp_d);
      check($sformatf("frame_done e%0d", e), frame_done, (e == 24 || e == 48));
    end

    // Mid-frame write: the current frame keeps the old digits.
    run_to(50);
    wr_en   = 1'b1;
    wr_data = 20'hFFFFF;
    tick();
    wr_en = 1'b0;
    run_to(54);
    check("old frame digit1", disp, lit(1, 20'h01234));
    run_to(66);
    check("old frame digit3", disp, lit(3, 20'h01234));
    run_to(71);
    check("no early frame_done", frame_done, 0);
    run_to(72);
    check("FFFFF digit0", disp, {4'b0001, 7'h71, 1'b1});
    check("frame_done e72", frame_done, 1);
    run_to(78);
    check("FFFFF digit1", disp, {4'b0010, 7'h71, 1'b1});
    run_to(84);
    check("FFFFF digit2", disp, {4'b0100, 7'h71, 1'b1});
    run_to(90);
    check("FFFFF digit3", disp, {4'b1000, 7'h71, 1'b1});

    // Write landing exactly on the boundary edge (edge 95) wins.
    run_to(94);
    wr_en   = 1'b1;
    wr_data = 20'h0000A;
    tick();
    wr_en = 1'b0;
    tick();
    check("boundary write digit0", disp, {4'b0001, 7'h77, 1'b0});
    check("boundary write frame_done", frame_done, 1);

    // Drop enable mid-digit-2 for 10 cycles, writing 0x00008 meanwhile.
    run_to(108);
    check("digit2 before disable", disp, lit(2, 20'h0000A));
    run_to(109);
    enable  = 1'b0;
    wr_en   = 1'b1;
    wr_data = 20'h00008;
    tick();
    wr_en = 1'b0;
    check("disabled dark", disp, 12'h000);
    check("disabled frame_done", frame_done, 0);
    run_to(115);
    check("disabled still dark", disp, 12'h000);
    run_to(119);
    enable = 1'b1;
    tick();
    check("re-enable digit0", disp, {4'b0001, 7'h7F, 1'b0});
    run_to(143);
    check("no frame_done before 24", frame_done, 0);
    tick();
    check("frame_done 24 after re-enable", frame_done, 1);
    check("re-enable frame digit0", disp, {4'b0001, 7'h7F, 1'b0});

    // Asynchronous reset during the blank phase of digit 1.
    run_to(153);
    check("digit1 before reset", disp, lit(1, 20'h00008));
    rst_n = 1'b0;
    #1;
    check("async reset disp", disp, 12'h000);
    check("async reset frame_done", frame_done, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held reset disp", disp, 12'h000);

    // Restart at digit 0, writing 0x00050 on the first edge.
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 20'h00050;
    edge_n  = -1;
    tick();
    wr_en = 1'b0;
    check("restart digit0", disp, lit(0, 20'h00000));
    run_to(6);
    check("restart digit1", disp, lit(1, 20'h00000));
    run_to(24);
    check("00050 digit0", disp, {4'b0001, 7'h3F, 1'b0});
    check("00050 frame_done", frame_done, 1);
    run_to(30);
    check("00050 digit1", disp, {4'b0010, 7'h6D, 1'b0});
    run_to(36);
    check("00050 digit2", disp, lit(2, 20'h00050));
    run_to(42);
    check("00050 digit3", disp, lit(3, 20'h00050));

    // All-zero value: digit 0 always shows "0".
    run_to(45);
    wr_en   = 1'b1;
    wr_data = 20'h00000;
    tick();
    wr_en = 1'b0;
    run_to(48);
    check("zero digit0", disp, {4'b0001, 7'h3F, 1'b0});
    run_to(54);
    check("zero digit1", disp, lit(1, 20'h00000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
